ex: RTL and testbench
=====================

EX -- requirements
Module: ex

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port ex_op  in  Oper_t  operation from the ID/EX register.
REQ-004 SHALL have port ex_pc  in  InstAddr_t  instruction address; passed through.
REQ-005 SHALL have ports ex_reg1, ex_reg2  in  Word_t  source operands (rs, rt).
REQ-006 SHALL have ports ex_reg_we, ex_reg_waddr  in  Bit_t, RegAddr_t  GPR write request.
REQ-007 SHALL have ports mem_pc, mem_result  out  InstAddr_t, Word_t  to the EX/MEM register.
REQ-008 SHALL have ports mem_reg_we, mem_reg_waddr  out  Bit_t, RegAddr_t  GPR write request, forwarded.
REQ-009 SHALL have ports mem_hilo_we, mem_hi, mem_lo  out  Bit_t, Word_t, Word_t  HI/LO write request and values.
REQ-010 SHALL have port stall_req  out  1  request for the stall controller to hold IF/ID/EX.

Function
REQ-011 Single-cycle ops: ADDU, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (shift amount ex_reg1[4:0], data ex_reg2); result on mem_result in the same cycle, combinational.
REQ-012 MULT/MULTU: 64-bit product in the same cycle; mem_hi = product[63:32], mem_lo = product[31:0], mem_hilo_we = 1.
REQ-013 DIV/DIVU: iterative restoring divider, 1 quotient bit per cycle, FSM states IDLE, BUSY, DONE.
REQ-014 IDLE with ex_op in {DIV, DIVU} and ex_reg2 != 0: latch operand magnitudes and signedness, clear the 5-bit counter, go to BUSY, stall_req = 1 (combinational) in that cycle.
REQ-015 BUSY: stall_req = 1; each cycle shift in one bit and increment the counter; after iteration 32 (counter == 31), go to DONE.
REQ-016 DONE: stall_req = 0, mem_hilo_we = 1, mem_lo = quotient, mem_hi = remainder; next state is IDLE unconditionally.
REQ-017 DIV latency: a divide first present in cycle N holds stall_req high for cycles N..N+32 (33 cycles); the result is presented in cycle N+33.
REQ-018 Signed DIV: divide magnitudes; negate the quotient when the operand signs differ; the remainder takes the sign of the dividend; 0x80000000 / -1 yields lo = 0x80000000, hi = 0.
REQ-019 Divide by zero (ex_reg2 == 0 in IDLE): go directly to DONE; lo = 0xFFFFFFFF, hi = ex_reg1; stall_req high for cycle N only.
REQ-020 The divider SHALL read only its latched operands while in BUSY; input changes during BUSY or DONE SHALL be ignored.
REQ-021 DONE -> IDLE SHALL NOT re-trigger a divide even if ex_op still shows DIV in DONE; the pipeline advances at the end of DONE.
REQ-022 mem_reg_we SHALL be 0 for MULT/MULTU/DIV/DIVU and for OP_NOP; otherwise it is ex_reg_we.
REQ-023 mem_hilo_we SHALL be 0 except for MULT/MULTU and in the DIV DONE cycle.
REQ-024 For OP_NOP and unknown ops: mem_result = 0, mem_reg_we = 0, mem_hilo_we = 0.

Reset
REQ-025 rst SHALL force the FSM to IDLE and clear the counter and the latched operands, including mid-divide; stall_req SHALL be 0 in the cycle after reset unless a new DIV is presented.
REQ-026 While rst = 1, outputs SHALL read 0 / NOP-equivalent: mem_result = 0, mem_reg_we = 0, mem_hilo_we = 0, stall_req = 0.

Structure
REQ-027 Oper_t, Word_t, InstAddr_t, RegAddr_t and Stall_t SHALL come from cpu_defs.svh; the new DivState_t enum (IDLE, BUSY, DONE) SHALL be added there.
REQ-028 The divider FSM and datapath SHALL be a sub-module named divider (ports: clk, rst, start, is_signed, dividend, divisor, busy, done, quotient, remainder); the ALU and multiplier SHALL remain in ex.

Verification
REQ-029 ADDU 0xFFFFFFFF + 0x00000001 -> mem_result = 0, mem_reg_we = 1, stall_req = 0.
REQ-030 MULT 0xFFFFFFFE (-2) x 3 -> mem_hi = 0xFFFFFFFF, mem_lo = 0xFFFFFFFA, mem_hilo_we = 1, same cycle.
REQ-031 DIV -7 / 2 issued at cycle N -> stall_req = 1 for N..N+32; at N+33 lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, hilo_we = 1.
REQ-032 DIVU 100 / 0 -> stall_req for one cycle only; next cycle lo = 0xFFFFFFFF, hi = 100.
REQ-033 rst asserted in BUSY cycle 10 -> FSM IDLE, stall_req = 0, no hilo_we; a following DIVU 9/4 gives lo = 2, hi = 1 after the full 33 stall cycles.
REQ-034 Operands changed during BUSY -> result unchanged; DIV held in DONE -> no second divide starts.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared CPU types for the execute stage: operand/address widths, ALU
// operation codes and the divider state encoding.
package ex_pkg;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;
  typedef logic [31:0] InstAddr_t;
  typedef logic [4:0]  RegAddr_t;
  typedef logic [5:0]  Stall_t;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUBU  = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOR   = 5'd6,
    OP_SLT   = 5'd7,
    OP_SLTU  = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_MULT  = 5'd12,
    OP_MULTU = 5'd13,
    OP_DIV   = 5'd14,
    OP_DIVU  = 5'd15
  } Oper_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } DivState_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic Word_t abs_word(input Word_t w, input logic sgn);
    Word_t r;
    if (sgn && w[31]) begin
      r = ~w + 32'd1;
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle over 32 BUSY
// cycles, operands latched at start so later input changes are ignored.
module divider
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  DivState_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsor_q, dsor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [32:0] trial_s;

  // Next-state and datapath update for the divide FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsor_d    = dsor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    trial_s   = {rem_q, quo_q[31]} - {1'b0, dsor_q};
    case (state_q)
      IDLE: begin
        if (start && (divisor == 32'd0)) begin
          state_d   = DONE;
          quo_d     = 32'hFFFF_FFFF;
          rem_d     = dividend;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else if (start) begin
          state_d   = BUSY;
          cnt_d     = 5'd0;
          quo_d     = abs_word(dividend, is_signed);
          rem_d     = 32'd0;
          dsor_d    = abs_word(divisor, is_signed);
          neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
          neg_rem_d = is_signed & dividend[31];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (!trial_s[32]) begin
          rem_d = trial_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // The stalled instruction retires here; never chain into a new divide.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dsor_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsor_q    <= dsor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Status flags and sign-corrected results.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (rst) begin
      busy = 1'b0;
      done = 1'b0;
    end else begin
      busy = ((state_q == IDLE) && start) || (state_q == BUSY);
      done = (state_q == DONE);
    end
    if (neg_quo_q) begin
      quotient = ~quo_q + 32'd1;
    end else begin
      quotient = quo_q;
    end
    if (neg_rem_q) begin
      remainder = ~rem_q + 32'd1;
    end else begin
      remainder = rem_q;
    end
  end

endmodule

// File: rtl/ex.sv
// Execute stage: combinational ALU and multiplier, plus the iterative
// divider which stalls the front of the pipeline while it runs.
module ex
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  Oper_t       ex_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic        ex_reg_we,
  input  logic [4:0]  ex_reg_waddr,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic        mem_reg_we,
  output logic [4:0]  mem_reg_waddr,
  output logic        mem_hilo_we,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stall_req
);

  logic        div_start_s;
  logic        div_signed_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] div_quo_s;
  logic [31:0] div_rem_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;

  assign div_start_s  = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
  assign div_signed_s = (ex_op == OP_DIV);
  assign stall_req    = div_busy_s;

  divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .is_signed (div_signed_s),
    .dividend  (ex_reg1),
    .divisor   (ex_reg2),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Full-width products; only one is selected per operation.
  always_comb begin
    smul_s = $signed({{32{ex_reg1[31]}}, ex_reg1}) * $signed({{32{ex_reg2[31]}}, ex_reg2});
    umul_s = {32'd0, ex_reg1} * {32'd0, ex_reg2};
  end

  // Result and write-request selection towards EX/MEM.
  always_comb begin
    mem_pc        = 32'd0;
    mem_result    = 32'd0;
    mem_reg_we    = 1'b0;
    mem_reg_waddr = 5'd0;
    mem_hilo_we   = 1'b0;
    mem_hi        = 32'd0;
    mem_lo        = 32'd0;
    if (rst) begin
      mem_pc = 32'd0;
    end else begin
      mem_pc        = ex_pc;
      mem_reg_waddr = ex_reg_waddr;
      mem_reg_we    = ex_reg_we;
      case (ex_op)
        OP_ADDU:  mem_result = ex_reg1 + ex_reg2;
        OP_SUBU:  mem_result = ex_reg1 - ex_reg2;
        OP_AND:   mem_result = ex_reg1 & ex_reg2;
        OP_OR:    mem_result = ex_reg1 | ex_reg2;
        OP_XOR:   mem_result = ex_reg1 ^ ex_reg2;
        OP_NOR:   mem_result = ~(ex_reg1 | ex_reg2);
        OP_SLT:   mem_result = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
        OP_SLTU:  mem_result = {31'd0, ex_reg1 < ex_reg2};
        OP_SLL:   mem_result = ex_reg2 << ex_reg1[4:0];
        OP_SRL:   mem_result = ex_reg2 >> ex_reg1[4:0];
        OP_SRA:   mem_result = $signed(ex_reg2) >>> ex_reg1[4:0];
        OP_MULT: begin
          mem_reg_we  = 1'b0;
          mem_hilo_we = 1'b1;
          mem_hi      = smul_s[63:32];
          mem_lo      = smul_s[31:0];
        end
        OP_MULTU: begin
          mem_reg_we  = 1'b0;
          mem_hilo_we = 1'b1;
          mem_hi      = umul_s[63:32];
          mem_lo      = umul_s[31:0];
        end
        OP_DIV, OP_DIVU: mem_reg_we = 1'b0;
        default:         mem_reg_we = 1'b0;
      endcase
      if (div_done_s) begin
        mem_hilo_we = 1'b1;
        mem_hi      = div_rem_s;
        mem_lo      = div_quo_s;
      end else begin
        mem_hilo_we = mem_hilo_we;
      end
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage: ALU, multiplier,
// divider latency/sign handling, divide-by-zero and mid-divide reset.
`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s: observed=%h expected=%h", tag, (obs), (exp)); \
    end \
  end

module tb_ex;
  import ex_pkg::*;

  logic        clk;
  logic        rst;
  Oper_t       ex_op;
  logic [31:0] ex_pc;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        ex_reg_we;
  logic [4:0]  ex_reg_waddr;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;
  logic        mem_reg_we;
  logic [4:0]  mem_reg_waddr;
  logic        mem_hilo_we;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        stall_req;

  int tests = 0;
  int fails = 0;

  ex dut (
    .clk           (clk),
    .rst           (rst),
    .ex_op         (ex_op),
    .ex_pc         (ex_pc),
    .ex_reg1       (ex_reg1),
    .ex_reg2       (ex_reg2),
    .ex_reg_we     (ex_reg_we),
    .ex_reg_waddr  (ex_reg_waddr),
    .mem_pc        (mem_pc),
    .mem_result    (mem_result),
    .mem_reg_we    (mem_reg_we),
    .mem_reg_waddr (mem_reg_waddr),
    .mem_hilo_we   (mem_hilo_we),
    .mem_hi        (mem_hi),
    .mem_lo        (mem_lo),
    .stall_req     (stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic alu(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input string tag);
    @(negedge clk);
    ex_op = op; ex_reg1 = a; ex_reg2 = b;
    #1;
    `CHK(tag, mem_result, exp_res)
  endtask

  // Divide issued at the next negedge; op stays on ex_op through DONE.
  task automatic run_div(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input bit scramble);
    int bad;
    @(negedge clk);
    ex_op = op; ex_reg1 = a; ex_reg2 = b;
    #1;
    `CHK("div_start_stall", stall_req, 1'b1)
    `CHK("div_reg_we", mem_reg_we, 1'b0)
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      #1;
      if (stall_req !== 1'b1 || mem_hilo_we !== 1'b0) bad++;
      if (scramble && k == 5) begin
        ex_reg1 = 32'h1234_5678;
        ex_reg2 = 32'h0000_0003;
      end
    end
    `CHK("div_busy_stall_cycles_bad", bad, 0)
    @(negedge clk);
    #1;
    `CHK("div_done_stall", stall_req, 1'b0)
    `CHK("div_done_hilo_we", mem_hilo_we, 1'b1)
    `CHK("div_lo", mem_lo, exp_lo)
    `CHK("div_hi", mem_hi, exp_hi)
    @(negedge clk);
    ex_op = OP_NOP;
    #1;
    `CHK("div_after_done_stall", stall_req, 1'b0)
    `CHK("div_after_done_hilo_we", mem_hilo_we, 1'b0)
  endtask

  initial begin
    rst = 1'b1; ex_op = OP_ADDU; ex_pc = 32'h0040_0000;
    ex_reg1 = 32'd1; ex_reg2 = 32'd2; ex_reg_we = 1'b1; ex_reg_waddr = 5'd9;
    #1;
    `CHK("rst_result", mem_result, 32'd0)
    `CHK("rst_reg_we", mem_reg_we, 1'b0)
    @(negedge clk);
    ex_op = OP_DIV; ex_reg2 = 32'd5;
    #1;
    `CHK("rst_stall", stall_req, 1'b0)
    `CHK("rst_hilo_we", mem_hilo_we, 1'b0)
    @(negedge clk);
    rst = 1'b0; ex_op = OP_NOP;
    #1;
    `CHK("post_rst_stall", stall_req, 1'b0)

    @(negedge clk);
    ex_op = OP_ADDU; ex_reg1 = 32'hFFFF_FFFF; ex_reg2 = 32'h0000_0001;
    #1;
    `CHK("addu_result", mem_result, 32'd0)
    `CHK("addu_reg_we", mem_reg_we, 1'b1)
    `CHK("addu_stall", stall_req, 1'b0)
    `CHK("addu_pc", mem_pc, 32'h0040_0000)
    `CHK("addu_waddr", mem_reg_waddr, 5'd9)

    alu(OP_SUBU, 32'd5,          32'd7,          32'hFFFF_FFFE, "subu");
    alu(OP_AND,  32'hF0F0_F0F0,  32'h0FFF_0000,  32'h00F0_0000, "and");
    alu(OP_OR,   32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F, "or");
    alu(OP_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F, "xor");
    alu(OP_NOR,  32'hF0F0_F0F0,  32'h0F0F_0000,  32'h0000_0F0F, "nor");
    alu(OP_SLT,  32'hFFFF_FFFF,  32'h0000_0001,  32'd1,         "slt");
    alu(OP_SLTU, 32'hFFFF_FFFF,  32'h0000_0001,  32'd0,         "sltu");
    alu(OP_SLL,  32'd31,         32'd1,          32'h8000_0000, "sll");
    alu(OP_SRL,  32'd4,          32'h8000_0000,  32'h0800_0000, "srl");
    alu(OP_SRA,  32'd4,          32'h8000_0000,  32'hF800_0000, "sra");

    @(negedge clk);
    ex_op = OP_MULT; ex_reg1 = 32'hFFFF_FFFE; ex_reg2 = 32'd3;
    #1;
    `CHK("mult_hi", mem_hi, 32'hFFFF_FFFF)
    `CHK("mult_lo", mem_lo, 32'hFFFF_FFFA)
    `CHK("mult_hilo_we", mem_hilo_we, 1'b1)
    `CHK("mult_reg_we", mem_reg_we, 1'b0)
    @(negedge clk);
    ex_op = OP_MULTU; ex_reg1 = 32'hFFFF_FFFF; ex_reg2 = 32'hFFFF_FFFF;
    #1;
    `CHK("multu_hi", mem_hi, 32'hFFFF_FFFE)
    `CHK("multu_lo", mem_lo, 32'h0000_0001)

    @(negedge clk);
    ex_op = OP_NOP; ex_reg1 = 32'd3; ex_reg2 = 32'd4;
    #1;
    `CHK("nop_result", mem_result, 32'd0)
    `CHK("nop_reg_we", mem_reg_we, 1'b0)
    `CHK("nop_hilo_we", mem_hilo_we, 1'b0)
    @(negedge clk);
    ex_op = Oper_t'(5'd25);
    #1;
    `CHK("unk_result", mem_result, 32'd0)
    `CHK("unk_reg_we", mem_reg_we, 1'b0)

    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    run_div(OP_DIV,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
    run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd16,         32'h0FFF_FFFF, 32'd15,        1'b0);

    @(negedge clk);
    ex_op = OP_DIVU; ex_reg1 = 32'd100; ex_reg2 = 32'd0;
    #1;
    `CHK("divz_stall", stall_req, 1'b1)
    @(negedge clk);
    #1;
    `CHK("divz_stall_next", stall_req, 1'b0)
    `CHK("divz_lo", mem_lo, 32'hFFFF_FFFF)
    `CHK("divz_hi", mem_hi, 32'd100)
    `CHK("divz_hilo_we", mem_hilo_we, 1'b1)
    @(negedge clk);
    ex_op = OP_NOP;
    #1;
    `CHK("divz_after_stall", stall_req, 1'b0)

    @(negedge clk);
    ex_op = OP_DIV; ex_reg1 = 32'd1000; ex_reg2 = 32'd7;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    `CHK("midrst_stall", stall_req, 1'b0)
    `CHK("midrst_hilo_we", mem_hilo_we, 1'b0)
    `CHK("midrst_result", mem_result, 32'd0)
    @(negedge clk);
    rst = 1'b0; ex_op = OP_NOP;
    #1;
    `CHK("after_rst_stall", stall_req, 1'b0)
    `CHK("after_rst_hilo_we", mem_hilo_we, 1'b0)
    run_div(OP_DIVU, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
